// File: rtl/peaxi4_pkg.sv
// peaxi4_pkg: shared AXI4 burst/response encodings and the beat-size helper
package peaxi4_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic [2:0] size_enc(input int strb_w);
    return strb_w == 16 ? 3'd4 : strb_w == 8 ? 3'd3 : strb_w == 4 ? 3'd2 : strb_w == 2 ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/peaxi4_sync_fifo.sv
// peaxi4_sync_fifo: first-word-fall-through FIFO with occupancy count
module peaxi4_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0] count,
  output logic full,
  output logic empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/peaxi4_master_v2.sv
// peaxi4_master_v2: queued AXI4 master bridge with outstanding-burst limits and read-space reservation
module peaxi4_master_v2
  import peaxi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int AQ_DEPTH = 8,
  parameter int DQ_DEPTH = 32,
  parameter int MAX_OUTST = 4,
  localparam int STRB_W = DATA_W / 8,
  localparam int OW = $clog2(MAX_OUTST + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic [ID_W-1:0] s_awid,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0] s_awlen,
  input  logic [1:0] s_awburst,
  input  logic s_awvalid,
  output logic s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic s_wlast,
  input  logic s_wvalid,
  output logic s_wready,
  output logic [ID_W-1:0] s_bid,
  output logic [1:0] s_bresp,
  output logic s_bvalid,
  input  logic s_bready,
  input  logic [ID_W-1:0] s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0] s_arlen,
  input  logic [1:0] s_arburst,
  input  logic s_arvalid,
  output logic s_arready,
  output logic [ID_W-1:0] s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0] s_rresp,
  output logic s_rlast,
  output logic s_rvalid,
  input  logic s_rready,
  output logic [ID_W-1:0] m_awid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0] m_awlen,
  output logic [2:0] m_awsize,
  output logic [1:0] m_awburst,
  output logic m_awvalid,
  input  logic m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic m_wlast,
  output logic m_wvalid,
  input  logic m_wready,
  input  logic [ID_W-1:0] m_bid,
  input  logic [1:0] m_bresp,
  input  logic m_bvalid,
  output logic m_bready,
  output logic [ID_W-1:0] m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0] m_arlen,
  output logic [2:0] m_arsize,
  output logic [1:0] m_arburst,
  output logic m_arvalid,
  input  logic m_arready,
  input  logic [ID_W-1:0] m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0] m_rresp,
  input  logic m_rlast,
  input  logic m_rvalid,
  output logic m_rready,
  output logic [OW-1:0] wr_outst,
  output logic [OW-1:0] rd_outst,
  output logic len_err
);
  localparam int AQW = $clog2(AQ_DEPTH + 1);
  localparam int DCW = $clog2(DQ_DEPTH + 1);
  localparam int AFW = ID_W + ADDR_W + 10;
  localparam int WFW = DATA_W + STRB_W + 1;
  localparam int RFW = ID_W + DATA_W + 3;
  logic [AQW-1:0] aw_count, ar_count;
  logic [DCW-1:0] w_count, r_count, r_resv;
  logic aw_full, aw_empty, ar_full, ar_empty, w_full, w_empty, r_full, r_empty;
  logic [AFW-1:0] aw_head, ar_head;
  logic [WFW-1:0] w_head;
  logic [RFW-1:0] r_head;
  logic [OW-1:0] credit;
  logic [31:0] free, need;
  logic aw_hs, w_hs, b_hs, ar_hs, rl_hs, ar_len_ok;
  logic unused_ok;
  assign unused_ok = &{1'b0, aw_full, ar_full, w_full, r_full};
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs = m_wvalid && m_wready;
  assign b_hs = s_bvalid && s_bready;
  assign ar_hs = m_arvalid && m_arready;
  assign rl_hs = s_rvalid && s_rready && s_rlast;
  assign ar_len_ok = 32'(s_arlen) < 32'(DQ_DEPTH);
  assign free = 32'(DQ_DEPTH) - 32'(r_count) - 32'(r_resv);
  assign need = 32'(m_arlen) + 32'd1;
  assign s_awready = !rst && aw_count < AQW'(AQ_DEPTH);
  assign s_arready = !rst && ar_count < AQW'(AQ_DEPTH) && ar_len_ok;
  assign s_wready = !rst && w_count < DCW'(DQ_DEPTH);
  assign m_awsize = size_enc(STRB_W);
  assign m_arsize = size_enc(STRB_W);
  assign {m_awid, m_awaddr, m_awlen, m_awburst} = aw_head;
  assign {m_arid, m_araddr, m_arlen, m_arburst} = ar_head;
  assign {m_wdata, m_wstrb, m_wlast} = w_head;
  assign {s_rid, s_rdata, s_rresp, s_rlast} = r_head;
  assign m_awvalid = !rst && !aw_empty && wr_outst < OW'(MAX_OUTST);
  assign m_wvalid = !rst && !w_empty && credit != '0;
  assign m_arvalid = !rst && !ar_empty && rd_outst < OW'(MAX_OUTST) && free >= need;
  assign s_rvalid = !rst && !r_empty;
  assign m_rready = 1'b1;
  assign s_bid = m_bid;
  assign s_bresp = m_bresp;
  assign s_bvalid = !rst && m_bvalid;
  assign m_bready = s_bready;
  peaxi4_sync_fifo #(.WIDTH(AFW), .DEPTH(AQ_DEPTH)) u_aw (
    .clk(clk), .rst(rst), .push(s_awvalid && s_awready), .din({s_awid, s_awaddr, s_awlen, s_awburst}),
    .pop(aw_hs), .dout(aw_head), .count(aw_count), .full(aw_full), .empty(aw_empty)
  );
  peaxi4_sync_fifo #(.WIDTH(AFW), .DEPTH(AQ_DEPTH)) u_ar (
    .clk(clk), .rst(rst), .push(s_arvalid && s_arready), .din({s_arid, s_araddr, s_arlen, s_arburst}),
    .pop(ar_hs), .dout(ar_head), .count(ar_count), .full(ar_full), .empty(ar_empty)
  );
  peaxi4_sync_fifo #(.WIDTH(WFW), .DEPTH(DQ_DEPTH)) u_w (
    .clk(clk), .rst(rst), .push(s_wvalid && s_wready), .din({s_wdata, s_wstrb, s_wlast}),
    .pop(w_hs), .dout(w_head), .count(w_count), .full(w_full), .empty(w_empty)
  );
  peaxi4_sync_fifo #(.WIDTH(RFW), .DEPTH(DQ_DEPTH)) u_r (
    .clk(clk), .rst(rst), .push(m_rvalid), .din({m_rid, m_rdata, m_rresp, m_rlast}),
    .pop(s_rready), .dout(r_head), .count(r_count), .full(r_full), .empty(r_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_outst <= '0;
      rd_outst <= '0;
      credit <= '0;
      r_resv <= '0;
      len_err <= 1'b0;
    end else begin
      wr_outst <= wr_outst + OW'(aw_hs) - OW'(b_hs);
      credit <= credit + OW'(aw_hs) - OW'(w_hs && m_wlast);
      rd_outst <= rd_outst + OW'(ar_hs) - OW'(rl_hs);
      r_resv <= r_resv + (ar_hs ? DCW'(need) : '0) - DCW'(m_rvalid);
      len_err <= len_err || (s_arvalid && !ar_len_ok);
    end
  end
endmodule
